// File: rtl/uart_burst_memory_controller.sv
// rtl/uart_burst_memory_controller.sv - byte-serial single/burst RAM access behind a uart
// Optional reply checksum enabled by defining UART_MEM_CHECKSUM_EN.
module uart_burst_memory_controller #(
  parameter int ADDR_BYTES = 2,
  parameter int DEPTH      = 8192,
  parameter int TIMEOUT    = 1200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       received,
  input  logic [7:0] rx_byte,
  input  logic       tx_busy,
  output logic       transmit,
  output logic [7:0] tx_byte,
  output logic       busy,
  output logic       timeout_err
);

  localparam int AW = 8 * ADDR_BYTES;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [1:0]    ADDR_LAST = 2'(ADDR_BYTES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_LEN,
    S_WDATA,
    S_RD_FETCH,
    S_RD_WAIT,
    S_RD_GUARD,
    S_CSUM_WAIT,
    S_CSUM_GUARD
  } state_t;

`ifdef UART_MEM_CHECKSUM_EN
  localparam state_t FINISH = S_CSUM_WAIT;
`else
  localparam state_t FINISH = S_IDLE;
`endif

  state_t          state;
  state_t          state_next;
  logic [AW-1:0]   addr;
  logic [8:0]      count;
  logic [1:0]      addr_idx;
  logic            is_read;
  logic            is_burst;
  logic [TW-1:0]   tmo_cnt;
  logic [7:0]      rd_data;
  logic [7:0]      mem [DEPTH];

  logic            timed;
  logic            last;
  logic            take_cmd;
  logic            take_addr;
  logic            take_len;
  logic            wr_en;
  logic            rd_en;
  logic            send_data;
  logic            step_rd;
  logic            tmo_fire;
`ifdef UART_MEM_CHECKSUM_EN
  logic [7:0]      csum;
  logic            send_csum;
`endif

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    take_cmd   = 1'b0;
    take_addr  = 1'b0;
    take_len   = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    send_data  = 1'b0;
    step_rd    = 1'b0;
    tmo_fire   = 1'b0;
`ifdef UART_MEM_CHECKSUM_EN
    send_csum  = 1'b0;
`endif
    timed = (state == S_ADDR) || (state == S_LEN) || (state == S_WDATA);
    last  = (count == 9'd1);
    case (state)
      S_IDLE: begin
        if (received && rx_byte >= 8'd1 && rx_byte <= 8'd4) begin
          take_cmd   = 1'b1;
          state_next = S_ADDR;
        end
      end
      S_ADDR: begin
        if (received) begin
          take_addr = 1'b1;
          if (addr_idx == ADDR_LAST)
            state_next = is_burst ? S_LEN : (is_read ? S_RD_FETCH : S_WDATA);
        end
      end
      S_LEN: begin
        if (received) begin
          take_len   = 1'b1;
          state_next = is_read ? S_RD_FETCH : S_WDATA;
        end
      end
      S_WDATA: begin
        if (received) begin
          wr_en = 1'b1;
          if (last) state_next = FINISH;
        end
      end
      S_RD_FETCH: begin
        rd_en      = 1'b1;
        state_next = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (!tx_busy) begin
          send_data  = 1'b1;
          state_next = S_RD_GUARD;
        end
      end
      // The uart raises is_transmitting one cycle late; never sample it here.
      S_RD_GUARD: begin
        step_rd    = 1'b1;
        state_next = last ? FINISH : S_RD_FETCH;
      end
`ifdef UART_MEM_CHECKSUM_EN
      S_CSUM_WAIT: begin
        if (!tx_busy) begin
          send_csum  = 1'b1;
          state_next = S_CSUM_GUARD;
        end
      end
      S_CSUM_GUARD: state_next = S_IDLE;
`endif
      default: state_next = S_IDLE;
    endcase
    // A byte arriving on the expiry cycle wins over the timeout.
    if (TIMEOUT != 0 && timed && !received && tmo_cnt == TMO_LAST) begin
      tmo_fire   = 1'b1;
      state_next = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      transmit    <= 1'b0;
      tx_byte     <= 8'h00;
      timeout_err <= 1'b0;
      addr        <= '0;
      count       <= 9'd0;
      addr_idx    <= 2'd0;
      is_read     <= 1'b0;
      is_burst    <= 1'b0;
      tmo_cnt     <= '0;
`ifdef UART_MEM_CHECKSUM_EN
      csum        <= 8'h00;
`endif
    end else begin
      timeout_err <= tmo_fire;
      tmo_cnt     <= (received || !timed) ? '0 : tmo_cnt + TW'(1);
`ifdef UART_MEM_CHECKSUM_EN
      transmit    <= send_data | send_csum;
`else
      transmit    <= send_data;
`endif
      if (take_cmd) begin
        is_read  <= rx_byte[0];
        is_burst <= (rx_byte >= 8'd3);
        addr     <= '0;
        addr_idx <= 2'd0;
        count    <= 9'd1;
`ifdef UART_MEM_CHECKSUM_EN
        csum     <= 8'h00;
`endif
      end
      if (take_addr) begin
        addr     <= (addr << 8) | AW'(rx_byte);
        addr_idx <= addr_idx + 2'd1;
      end
      if (take_len) count <= {1'b0, rx_byte} + 9'd1;
      if (wr_en || step_rd) begin
        addr  <= addr + AW'(1);
        count <= count - 9'd1;
      end
      if (send_data) tx_byte <= rd_data;
`ifdef UART_MEM_CHECKSUM_EN
      if (wr_en)     csum    <= csum ^ rx_byte;
      if (send_data) csum    <= csum ^ rd_data;
      if (send_csum) tx_byte <= csum;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[addr[IW-1:0]] <= rx_byte;
    if (rd_en)         rd_data <= mem[addr[IW-1:0]];
  end

endmodule
